dmem: RTL and testbench

Data memory for the project CPU's load/store path.
- A byte-writable RAM window at 0x8000_0000.
- A 3-word read-only constant block at 0x0010_0000.
- Reads are combinational; writes commit on the rising clock edge.
- A bound checker flags accesses that hit neither region.

---
 rtl/dmem.sv | 89 ++++++++
 tb/tb_dmem.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dmem.sv
// Data memory: byte-writable RAM window plus a 3-word read-only constant block.
// Reads and the out-of-bound flag are combinational; writes commit on rising clk.
`default_nettype none

module dmem #(
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] ROM_BASE  = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dmemRW,
  input  logic [3:0]  w_en,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        outofbound
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [31:0] ROM_BYTES = 32'd12;

  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  logic [31:0] mem [RAM_WORDS] = '{default: '0};

  logic [31:0]      ram_off;
  logic [31:0]      rom_off;
  logic             ram_hit;
  logic             rom_hit;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      rom_word;
  logic             wr_ok;
  logic             unused_bits;

  // Offset subtraction wraps for addresses below the base, so one unsigned
  // compare covers both ends of each window.
  assign ram_off = addr - RAM_BASE;
  assign rom_off = addr - ROM_BASE;
  assign ram_hit = (ram_off < RAM_BYTES);
  assign rom_hit = (rom_off < ROM_BYTES);
  assign ram_idx = ram_off[IDX_W+1:2];

  assign unused_bits = ^{addr[1:0], ram_off[31:IDX_W+2], ram_off[1:0], rom_off[31:4], rom_off[1:0]};

  always_comb begin
    rom_word = '0;
    case (rom_off[3:2])
      2'd0:    rom_word = 32'h1198_7251;
      2'd1:    rom_word = 32'h1879_0475;
      2'd2:    rom_word = 32'h1025_7233;
      default: rom_word = '0;
    endcase
  end

  always_comb begin
    dout       = '0;
    outofbound = 1'b0;
    wr_ok      = 1'b0;
    if (rst) begin
      case (dmemRW)
        MODE_READ: begin
          if (ram_hit)      dout       = mem[ram_idx];
          else if (rom_hit) dout       = rom_word;
          else              outofbound = 1'b1;
        end
        MODE_WRITE: begin
          if (ram_hit) wr_ok      = 1'b1;
          else         outofbound = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wr_ok already carries rst, so a reset asserted before the edge blocks the write.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_en[i]) mem[ram_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem.sv
// Scoreboard bench for dmem: stimulus pushes expected {dout,outofbound}, a monitor pops and compares.
`default_nettype none

module tb_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dmemRW;
  logic [3:0]  w_en;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        outofbound;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  dmem dut (
    .clk(clk), .rst(rst), .dmemRW(dmemRW), .w_en(w_en),
    .addr(addr), .din(din), .dout(dout), .outofbound(outofbound)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
  logic [32:0] m_exp;
  string       m_name;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      checks++;
      if ({dout, outofbound} !== m_exp) begin
        errors++;
        $display("FAIL %s: got dout=%h oob=%b, expected dout=%h oob=%b",
                 m_name, dout, outofbound, m_exp[32:1], m_exp[0]);
      end
    end
  end

  // One access per cycle; mid_rst drops reset partway through the cycle before the sample.
  task automatic apply(input string nm, input logic r, input logic [1:0] mode,
                       input logic [3:0] we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e_dout, input logic e_oob, input logic mid_rst = 1'b0);
    @(posedge clk);
    #1;
    rst = r; dmemRW = mode; w_en = we; addr = a; din = d;
    exp_q.push_back({e_dout, e_oob});
    name_q.push_back(nm);
    if (mid_rst) begin
      #3 rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; dmemRW = 2'b00; w_en = 4'h0; addr = '0; din = '0;

    // Reset behaviour
    apply("reset_idle",       0, 2'b00, 4'h0, 32'h8000_0000, 32'h0,         32'h0, 0);
    apply("reset_write",      0, 2'b01, 4'h1, 32'h8000_0000, 32'h2022_1118, 32'h0, 0);
    apply("reset_write2",     0, 2'b01, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    apply("reset_read_rom",   0, 2'b10, 4'h0, 32'h0010_0000, 32'h0,         32'h0, 0);
    apply("ram_after_reset",  1, 2'b10, 4'h0, 32'h8000_0000, 32'h0,         32'h0, 0);

    // Byte lanes, one per edge
    apply("wr_lane0",         1, 2'b01, 4'b0001, 32'h8000_0000, 32'h2022_1118, 32'h0, 0);
    apply("rd_lane0",         1, 2'b10, 4'h0,    32'h8000_0000, 32'h0,         32'h0000_0018, 0);
    apply("wr_lane1",         1, 2'b01, 4'b0010, 32'h8000_0000, 32'h2022_1118, 32'h0, 0);
    apply("wr_lane2",         1, 2'b01, 4'b0100, 32'h8000_0000, 32'h2022_1118, 32'h0, 0);
    apply("wr_lane3",         1, 2'b01, 4'b1000, 32'h8000_0000, 32'h2022_1118, 32'h0, 0);
    apply("wr_lane01",        1, 2'b01, 4'b0011, 32'h8000_0000, 32'h2022_1118, 32'h0, 0);
    apply("rd_full_word",     1, 2'b10, 4'h0,    32'h8000_0000, 32'h0,         32'h2022_1118, 0);

    // Partial writes on a fresh word
    apply("wr_lo_half",       1, 2'b01, 4'b0011, 32'h8000_0004, 32'h2022_1118, 32'h0, 0);
    apply("rd_lo_half",       1, 2'b10, 4'h0,    32'h8000_0004, 32'h0,         32'h0000_1118, 0);
    apply("wr_hi_half",       1, 2'b01, 4'b1100, 32'h8000_0004, 32'hAABB_CCDD, 32'h0, 0);
    apply("rd_merged",        1, 2'b10, 4'h0,    32'h8000_0004, 32'h0,         32'hAABB_1118, 0);
    apply("wr_no_lanes",      1, 2'b01, 4'b0000, 32'h8000_0004, 32'h1234_5678, 32'h0, 0);
    apply("rd_no_lanes",      1, 2'b10, 4'h0,    32'h8000_0004, 32'h0,         32'hAABB_1118, 0);
    apply("rd_ignore_lsb",    1, 2'b10, 4'h0,    32'h8000_0007, 32'h0,         32'hAABB_1118, 0);

    // Constant block
    apply("rom_word0",        1, 2'b10, 4'h0, 32'h0010_0000, 32'h0, 32'h1198_7251, 0);
    apply("rom_word1",        1, 2'b10, 4'h0, 32'h0010_0004, 32'h0, 32'h1879_0475, 0);
    apply("rom_word2",        1, 2'b10, 4'h0, 32'h0010_0008, 32'h0, 32'h1025_7233, 0);
    apply("idle_00",          1, 2'b00, 4'h0, 32'h0010_0008, 32'h0, 32'h0, 0);
    apply("idle_11",          1, 2'b11, 4'hF, 32'h0010_0008, 32'h0, 32'h0, 0);

    // Boundaries
    apply("rom_past_end",     1, 2'b10, 4'h0, 32'h0010_000C, 32'h0,         32'h0, 1);
    apply("rom_below",        1, 2'b10, 4'h0, 32'h000F_FFFC, 32'h0,         32'h0, 1);
    apply("wr_rom",           1, 2'b01, 4'hF, 32'h0010_0000, 32'hDEAD_BEEF, 32'h0, 1);
    apply("rom_after_wr",     1, 2'b10, 4'h0, 32'h0010_0000, 32'h0,         32'h1198_7251, 0);
    apply("wr_ram_past_end",  1, 2'b01, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0, 1);
    apply("rd_ram_past_end",  1, 2'b10, 4'h0, 32'h8000_1000, 32'h0,         32'h0, 1);
    apply("no_alias_word0",   1, 2'b10, 4'h0, 32'h8000_0000, 32'h0,         32'h2022_1118, 0);
    apply("wr_ram_below",     1, 2'b01, 4'hF, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 32'h0, 1);
    apply("wr_ram_last",      1, 2'b01, 4'hF, 32'h8000_0FFC, 32'h1234_5678, 32'h0, 0);
    apply("rd_ram_last",      1, 2'b10, 4'h0, 32'h8000_0FFC, 32'h0,         32'h1234_5678, 0);
    apply("rd_ram_last_kept", 1, 2'b10, 4'h0, 32'h8000_0FFC, 32'h0,         32'h1234_5678, 0);

    // Reset dropped mid-write, before the clock edge
    apply("mid_rst_write",    1, 2'b01, 4'hF, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 0, 1'b1);
    apply("mid_rst_blocked",  1, 2'b10, 4'h0, 32'h8000_0008, 32'h0,         32'h0, 0);
    apply("rd_word0_final",   1, 2'b10, 4'h0, 32'h8000_0000, 32'h0,         32'h2022_1118, 0);

    // Drain: the monitor must have consumed every expectation within one cycle.
    @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
